// File: rtl/z16_mem_copy_engine_pkg.sv
// Shared definitions for the Z16 block-copy engine: bus widths and FSM state encodings.
package z16_mem_copy_engine_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } dma_state_e;

endpackage

// File: rtl/z16_mem_copy_engine_ctr.sv
// Remaining-word down counter for the Z16 copy engine.
// zero_o flags an empty count, last_o flags that the word being written is the final one.
module z16_dma_ctr #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] loadValue_i,
  input  logic         dec_i,
  output logic         zero_o,
  output logic         last_o
);

  logic [W-1:0] remaining_q;
  logic [W-1:0] remaining_d;

  // Load wins over decrement; the count never goes below zero.
  always_comb begin
    remaining_d = remaining_q;
    if (load_i) begin
      remaining_d = loadValue_i;
    end else if (dec_i && (remaining_q != '0)) begin
      remaining_d = remaining_q - W'(1);
    end
  end

  // Remaining-word register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      remaining_q <= '0;
    end else begin
      remaining_q <= remaining_d;
    end
  end

  assign zero_o = (remaining_q == '0);
  assign last_o = (remaining_q == W'(1));

endmodule

// File: rtl/z16_mem_copy_engine.sv
// Z16 bus-master block-copy engine: reads words from a source area and writes them to a
// destination area one word at a time over the data-memory port.
// Optional feature: define Z16_DMA_FILL_EN to add fill mode (i_fill=1 writes i_pattern
// to every destination word, one WRITE cycle per word, no reads).
// A zero-length command is recognised in one address-less READ cycle, using the counter's
// registered zero flag, so o_done follows two cycles after the start cycle.
module z16_mem_copy_engine
  import z16_mem_copy_engine_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int LEN_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_src,
  input  logic [ADDR_W-1:0] i_dst,
  input  logic [LEN_W-1:0]  i_len,
  input  logic              i_fill,
  input  logic [DATA_W-1:0] i_pattern,
  output logic              o_busy,
  output logic              o_done,
  output logic [LEN_W-1:0]  o_count,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_wen,
  output logic [DATA_W-1:0] o_mem_data,
  input  logic [DATA_W-1:0] i_mem_data
);

  localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);

  dma_state_e        state_q;
  logic [1:0]        latCnt_q;
  logic [ADDR_W-1:0] srcPtr_q;
  logic [ADDR_W-1:0] dstPtr_q;
  logic [ADDR_W-1:0] memAddr_q;
  logic              memWen_q;
  logic [DATA_W-1:0] wordBuf_q;
  logic              busy_q;
  logic              done_q;
  logic [LEN_W-1:0]  count_q;

  logic              ctrLoad;
  logic              ctrDec;
  logic              ctrZero;
  logic              ctrLast;
  logic              fillStart;
  logic              fillMode;
  logic [DATA_W-1:0] fillValue;
  logic [DATA_W-1:0] fillNext;

`ifdef Z16_DMA_FILL_EN
  logic              fillMode_q;
  logic [DATA_W-1:0] pattern_q;

  // Fill-mode selection and pattern are captured with the command.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      fillMode_q <= 1'b0;
      pattern_q  <= '0;
    end else if ((state_q == ST_IDLE) && i_start) begin
      fillMode_q <= i_fill;
      pattern_q  <= i_pattern;
    end
  end

  assign fillStart = i_fill && (i_len != '0);
  assign fillValue = i_pattern;
  assign fillMode  = fillMode_q;
  assign fillNext  = pattern_q;
`else
  logic unusedFillInputs;
  assign unusedFillInputs = ^{i_fill, i_pattern};
  assign fillStart = 1'b0;
  assign fillValue = '0;
  assign fillMode  = 1'b0;
  assign fillNext  = '0;
`endif

  assign ctrLoad = (state_q == ST_IDLE) && i_start;
  assign ctrDec  = (state_q == ST_WRITE);

  z16_dma_ctr #(.W(LEN_W)) u_ctr (
    .clk_i       (i_clk),
    .rst_i       (i_rst),
    .load_i      (ctrLoad),
    .loadValue_i (i_len),
    .dec_i       (ctrDec),
    .zero_o      (ctrZero),
    .last_o      (ctrLast)
  );

  // Transfer sequencer; every memory-port and status output is registered here.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      latCnt_q  <= '0;
      srcPtr_q  <= '0;
      dstPtr_q  <= '0;
      memAddr_q <= '0;
      memWen_q  <= 1'b0;
      wordBuf_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      count_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            srcPtr_q <= i_src;
            dstPtr_q <= i_dst;
            count_q  <= '0;
            busy_q   <= 1'b1;
            if (fillStart) begin
              state_q   <= ST_WRITE;
              memAddr_q <= i_dst;
              memWen_q  <= 1'b1;
              wordBuf_q <= fillValue;
            end else begin
              state_q   <= ST_READ;
              memAddr_q <= (i_len != '0) ? i_src : '0;
            end
          end
        end
        ST_READ: begin
          if (ctrZero) begin
            state_q   <= ST_DONE;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            memAddr_q <= '0;
          end else begin
            state_q  <= ST_WAIT;
            latCnt_q <= '0;
          end
        end
        ST_WAIT: begin
          if (latCnt_q == LAT_LAST) begin
            wordBuf_q <= i_mem_data;
            memAddr_q <= dstPtr_q;
            memWen_q  <= 1'b1;
            state_q   <= ST_WRITE;
          end else begin
            latCnt_q <= latCnt_q + 2'd1;
          end
        end
        ST_WRITE: begin
          srcPtr_q <= srcPtr_q + 16'd1;
          dstPtr_q <= dstPtr_q + 16'd1;
          count_q  <= count_q + LEN_W'(1);
          if (ctrLast) begin
            state_q   <= ST_DONE;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            memWen_q  <= 1'b0;
            memAddr_q <= '0;
          end else if (fillMode) begin
            memAddr_q <= dstPtr_q + 16'd1;
            wordBuf_q <= fillNext;
          end else begin
            state_q   <= ST_READ;
            memWen_q  <= 1'b0;
            memAddr_q <= srcPtr_q + 16'd1;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q   <= ST_IDLE;
          memWen_q  <= 1'b0;
          memAddr_q <= '0;
          busy_q    <= 1'b0;
          done_q    <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_count    = count_q;
  assign o_mem_addr = memAddr_q;
  assign o_mem_wen  = memWen_q;
  assign o_mem_data = wordBuf_q;

endmodule

// File: tb/tb_z16_mem_copy_engine.sv
// Self-checking bench for z16_mem_copy_engine with a behavioural data memory.
// Expected writes are queued when a command is issued and matched as the engine writes.
module tb_z16_mem_copy_engine;

  localparam int RD_LAT = 1;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] src = '0;
  logic [15:0] dst = '0;
  logic [15:0] len = '0;
  logic        fill = 1'b0;
  logic [15:0] pattern = '0;
  logic        busy;
  logic        done;
  logic [15:0] count;
  logic [15:0] memAddr;
  logic        memWen;
  logic [15:0] memWrData;
  logic [15:0] memRdData;

  logic [15:0] mem [0:65535];
  logic [15:0] rdPipe [RD_LAT];

  wr_t sbQueue [$];
  int  testsRun = 0;
  int  testsFailed = 0;
  int  wenCount = 0;
  int  doneCount = 0;
  logic prevWen = 1'b0;
  logic fillTest = 1'b0;

  z16_mem_copy_engine #(.RD_LAT(RD_LAT), .LEN_W(16)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_src      (src),
    .i_dst      (dst),
    .i_len      (len),
    .i_fill     (fill),
    .i_pattern  (pattern),
    .o_busy     (busy),
    .o_done     (done),
    .o_count    (count),
    .o_mem_addr (memAddr),
    .o_mem_wen  (memWen),
    .o_mem_data (memWrData),
    .i_mem_data (memRdData)
  );

  always #5 clk = ~clk;

  // Data memory: synchronous write, RD_LAT-cycle read pipeline.
  always @(posedge clk) begin
    if (memWen) mem[memAddr] <= memWrData;
    rdPipe[0] <= mem[memAddr];
    for (int i = 1; i < RD_LAT; i++) rdPipe[i] <= rdPipe[i-1];
  end
  assign memRdData = rdPipe[RD_LAT-1];

  // Count one comparison and report it if it does not hold.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Write monitor: every memory write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && memWen) begin
      wenCount++;
      if (!fillTest) checkOutput("wenGap", 32'(prevWen), 32'd0);
      if (sbQueue.size() == 0) begin
        checkOutput("wrUnexpected", 32'(memWen), 32'd0);
      end else begin
        wr_t e;
        e = sbQueue.pop_front();
        checkOutput("wrAddr", 32'(memAddr), 32'(e.addr));
        checkOutput("wrData", 32'(memWrData), 32'(e.data));
      end
    end
    if (!rst && done) doneCount++;
    prevWen = memWen;
  end

  // Queue the writes a copy should produce, using the bench's own memory image.
  task automatic expectCopy(input logic [15:0] s, input logic [15:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      wr_t e;
      e.addr = d + 16'(i);
      e.data = mem[s + 16'(i)];
      sbQueue.push_back(e);
    end
  endtask

  // Issue one command; start is sampled on the posedge this task waits for.
  task automatic applyStimulus(input logic [15:0] s, input logic [15:0] d, input logic [15:0] n,
                               input logic f, input logic [15:0] p);
    @(negedge clk);
    src = s; dst = d; len = n; fill = f; pattern = p; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    src = ~s; dst = ~d; len = 16'h00FF; fill = 1'b0; pattern = ~p;
  endtask

  // Wait (bounded) for o_done; check edge latency from the sampling edge, count and pulse shape.
  task automatic waitDone(input string tag, input int expLat, input int expCount);
    int lat;
    lat = 0;
    while (lat < 200) begin
      @(posedge clk);
      lat++;
      #1;
      if (done) break;
    end
    if (!done) begin
      checkOutput({tag, "_doneTimeout"}, 32'(done), 32'd1);
    end else begin
      checkOutput({tag, "_latency"}, 32'(lat), 32'(expLat));
      checkOutput({tag, "_count"}, 32'(count), 32'(expCount));
      checkOutput({tag, "_busyAtDone"}, 32'(busy), 32'd0);
      @(posedge clk);
      #1;
      checkOutput({tag, "_donePulse"}, 32'(done), 32'd0);
      checkOutput({tag, "_idleAddr"}, 32'(memAddr), 32'd0);
      checkOutput({tag, "_countHold"}, 32'(count), 32'(expCount));
    end
    checkOutput({tag, "_sbDrained"}, 32'(sbQueue.size()), 32'd0);
  endtask

  initial begin
    int wenBase;
    int doneBase;
    int seen;

    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int wenBase;
    int doneBase;
    int seen;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_addr", 32'(memAddr), 32'd0);
    checkOutput("rst_wen", 32'(memWen), 32'd0);
    checkOutput("rst_data", 32'(memWrData), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Plain three-word copy.
    mem[16'h0100] = 16'h1111;
    mem[16'h0101] = 16'h2222;
    mem[16'h0102] = 16'h3333;
    expectCopy(16'h0100, 16'h8000, 3);
    applyStimulus(16'h0100, 16'h8000, 16'd3, 1'b0, 16'h0);
    checkOutput("copy_busy", 32'(busy), 32'd1);
    waitDone("copy", 9, 3);
    checkOutput("copy_mem0", 32'(mem[16'h8000]), 32'h1111);
    checkOutput("copy_mem1", 32'(mem[16'h8001]), 32'h2222);
    checkOutput("copy_mem2", 32'(mem[16'h8002]), 32'h3333);

    // Zero length: no memory write, o_done two cycles after the start cycle.
    wenBase = wenCount;
    applyStimulus(16'h1234, 16'h4321, 16'd0, 1'b0, 16'h0);
    waitDone("zero", 1, 0);
    checkOutput("zero_noWen", 32'(wenCount - wenBase), 32'd0);

    // Pointer wrap at the top of the address space.
    mem[16'hFFFF] = 16'hAAAA;
    mem[16'h0000] = 16'hBBBB;
    expectCopy(16'hFFFF, 16'h7FFF, 2);
    applyStimulus(16'hFFFF, 16'h7FFF, 16'd2, 1'b0, 16'h0);
    waitDone("wrap", 6, 2);
    checkOutput("wrap_mem0", 32'(mem[16'h7FFF]), 32'hAAAA);
    checkOutput("wrap_mem1", 32'(mem[16'h8000]), 32'hBBBB);

    // A second start during a copy is ignored.
    mem[16'hA000] = 16'hDEAD;
    mem[16'h0200] = 16'h7777;
    expectCopy(16'h0100, 16'h9000, 3);
    applyStimulus(16'h0100, 16'h9000, 16'd3, 1'b0, 16'h0);
    repeat (3) @(posedge clk);
    applyStimulus(16'h0200, 16'hA000, 16'd1, 1'b0, 16'h0);
    waitDone("busyStart", 5, 3);
    checkOutput("busyStart_mem2", 32'(mem[16'h9002]), 32'h3333);
    checkOutput("busyStart_untouched", 32'(mem[16'hA000]), 32'hDEAD);

    // Asynchronous reset while the second word is being written.
    mem[16'hB000] = 16'hDEAD;
    mem[16'hB001] = 16'hDEAD;
    expectCopy(16'h0100, 16'hB000, 3);
    doneBase = doneCount;
    applyStimulus(16'h0100, 16'hB000, 16'd3, 1'b0, 16'h0);
    seen = 0;
    for (int c = 0; c < 50 && seen < 2; c++) begin
      @(posedge clk);
      #1;
      if (memWen) seen++;
    end
    checkOutput("rstMid_secondWrite", 32'(seen), 32'd2);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("rstMid_wen", 32'(memWen), 32'd0);
    checkOutput("rstMid_busy", 32'(busy), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    sbQueue.delete();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstMid_noDone", 32'(doneCount - doneBase), 32'd0);
    checkOutput("rstMid_idleBusy", 32'(busy), 32'd0);
    checkOutput("rstMid_mem0", 32'(mem[16'hB000]), 32'h1111);
    checkOutput("rstMid_mem1", 32'(mem[16'hB001]), 32'hDEAD);

`ifdef Z16_DMA_FILL_EN
    // Fill mode: one WRITE cycle per word, pattern everywhere, source ignored.
    fillTest = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_t e;
      e.addr = 16'h8FFF + 16'(i);
      e.data = 16'h5555;
      sbQueue.push_back(e);
    end
    applyStimulus(16'h0100, 16'h8FFF, 16'd4, 1'b1, 16'h5555);
    waitDone("fill", 4, 4);
    checkOutput("fill_memFirst", 32'(mem[16'h8FFF]), 32'h5555);
    checkOutput("fill_memLast", 32'(mem[16'h9002]), 32'h5555);
    fillTest = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
